// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter giving two requesters 3-cycle read access to a combinational ROM
module rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic ptr, win, oor, sel_win;
  logic [ADDR_W-1:0] sel_addr;
  always_comb begin
    sel_win  = (m0_req && m1_req) ? ptr : m1_req;
    sel_addr = sel_win ? m1_addr : m0_addr;
    state_n  = state == IDLE   ? ((m0_req || m1_req) ? ACCESS : IDLE) :
               state == ACCESS ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      ptr      <= 1'b0;
      win      <= 1'b0;
      oor      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (m0_req || m1_req) begin
          rom_addr <= sel_addr & ~ADDR_W'(3);
          win      <= sel_win;
          oor      <= (sel_addr >> (ROM_AW + 2)) != '0;
        end
        ACCESS: if (win) m1_rdata <= oor ? '0 : rom_data;
                else     m0_rdata <= oor ? '0 : rom_data;
        DONE: ptr <= ~win;
        default: ;
      endcase
    end
  end
  // responses are decoded straight from state so reset kills them instantly
  assign busy      = state != IDLE;
  assign m0_rvalid = state == DONE && !win;
  assign m1_rvalid = state == DONE && win;
  assign m0_err    = m0_rvalid && oor;
  assign m1_err    = m1_rvalid && oor;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: transaction-level model plus directed literal checks for rom_arbiter
module tb_rom_arbiter;
  logic clk = 0, reset = 1;
  logic m0_req = 0, m1_req = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_rdata, m1_rdata, rom_addr, rom_data;
  logic m0_rvalid, m0_err, m1_rvalid, m1_err, busy;
  int vectors = 0, errs = 0;

  rom_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] i);
    return i == 0 ? 32'h0010_8233 : (32'hC0DE_0000 | i);
  endfunction

  logic [31:0] rom_idx;
  assign rom_idx  = {17'd0, rom_addr[16:2]};
  assign rom_data = rom_fn(rom_idx);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // model: one outstanding transaction, selected at an edge, completing two edges later
  int ecnt = 0, t_sel = 0, mw = 0, mptr = 0;
  bit pend = 0, mo = 0;
  logic [31:0] maddr = 0, resp = 0, md0 = 0, md1 = 0;
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      pend = 0; mptr = 0; maddr = 0; md0 = 0; md1 = 0;
    end else begin
      ecnt++;
      if (pend) begin
        if (ecnt - t_sel == 1) begin
          if (mw == 1) md1 = resp; else md0 = resp;
        end
        if (ecnt - t_sel == 2) begin
          pend = 0;
          mptr = 1 - mw;
        end
      end else if (m0_req || m1_req) begin
        logic [31:0] a;
        mw    = (m0_req && m1_req) ? mptr : (m1_req ? 1 : 0);
        a     = mw == 1 ? m1_addr : m0_addr;
        mo    = a >= 32'h0002_0000;
        maddr = a - (a % 4);
        resp  = mo ? 32'd0 : rom_fn(a / 4);
        t_sel = ecnt;
        pend  = 1;
      end
    end
  end

  typedef struct {int who; int cyc; logic [31:0] data; logic err; logic [31:0] acc;} ev_t;
  ev_t lg[$];
  int ncyc = 0;
  logic [31:0] prev_addr = 0;
  initial forever begin
    bit dn;
    @(negedge clk);
    ncyc++;
    dn = pend && (ecnt - t_sel == 1);
    chk("busy", {31'd0, busy}, {31'd0, pend});
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, dn && mw == 0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, dn && mw == 1});
    chk("m0_err", {31'd0, m0_err}, {31'd0, dn && mw == 0 && mo});
    chk("m1_err", {31'd0, m1_err}, {31'd0, dn && mw == 1 && mo});
    chk("m0_rdata", m0_rdata, md0);
    chk("m1_rdata", m1_rdata, md1);
    chk("rom_addr", rom_addr, maddr);
    if (m0_rvalid) lg.push_back('{0, ncyc, m0_rdata, m0_err, prev_addr});
    if (m1_rvalid) lg.push_back('{1, ncyc, m1_rdata, m1_err, prev_addr});
    prev_addr = rom_addr;
  end

  // each requester performs n transactions, holding req until its rvalid
  task automatic run(input int n0, input int n1, input logic [31:0] a0, input logic [31:0] a1);
    int c0 = 0, c1 = 0, t = 0;
    m0_addr = a0; m1_addr = a1;
    m0_req = n0 > 0; m1_req = n1 > 0;
    while ((c0 < n0 || c1 < n1) && t < 200) begin
      @(negedge clk);
      t++;
      if (m0_rvalid) c0++;
      if (m1_rvalid) c1++;
      @(posedge clk); #2;
      m0_req = c0 < n0; m1_req = c1 < n1;
    end
    if (t >= 200) begin
      errs++;
      $display("FAIL timeout: got %0d/%0d responses expected %0d/%0d", c0, c1, n0, n1);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
  endtask

  task automatic ev(input int k, input int who, input logic [31:0] data, input logic err);
    chk("ev_count", lg.size() > k, 1);
    if (lg.size() > k) begin
      chk("ev_who", lg[k].who, who);
      chk("ev_data", lg[k].data, data);
      chk("ev_err", {31'd0, lg[k].err}, {31'd0, err});
    end
  endtask

  int start;
  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    reset = 0;

    lg.delete(); start = ncyc;
    run(1, 0, 32'h0, 32'h0);
    ev(0, 0, 32'h0010_8233, 0);
    if (lg.size() > 0) chk("m0_latency", lg[0].cyc - start, 3);

    do_reset();
    lg.delete();
    run(1, 1, 32'h4, 32'h8);
    ev(0, 0, 32'hC0DE_0001, 0);
    ev(1, 1, 32'hC0DE_0002, 0);
    if (lg.size() > 1) chk("rr_spacing", lg[1].cyc - lg[0].cyc, 3);

    lg.delete();
    run(2, 2, 32'h10, 32'h14);
    ev(0, 0, 32'hC0DE_0004, 0);
    ev(1, 1, 32'hC0DE_0005, 0);
    ev(2, 0, 32'hC0DE_0004, 0);
    ev(3, 1, 32'hC0DE_0005, 0);

    lg.delete();
    run(0, 1, 32'h0, 32'h0002_0000);
    ev(0, 1, 32'h0, 1);
    if (lg.size() > 0) chk("oor_access_addr", lg[0].acc, 32'h0002_0000);
    chk("m0_rdata_held", m0_rdata, 32'hC0DE_0004);

    lg.delete();
    run(1, 0, 32'h6, 32'h0);
    ev(0, 0, 32'hC0DE_0001, 0);
    if (lg.size() > 0) chk("misalign_access_addr", lg[0].acc, 32'h4);

    m0_addr = 32'hC; m0_req = 1;
    @(posedge clk); #2;
    chk("in_access", {31'd0, busy}, 1);
    lg.delete();
    reset = 1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_m0_rdata", m0_rdata, 0);
    chk("abort_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 0);
    chk("abort_err", {30'd0, m0_err, m1_err}, 0);
    m0_req = 0;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    chk("abort_no_pulse", lg.size(), 0);
    run(1, 1, 32'h8, 32'hC);
    ev(0, 0, 32'hC0DE_0002, 0);
    ev(1, 1, 32'hC0DE_0003, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
